// File: rtl/superh16_pkg.sv
// Shared types and helpers for the superh16 branch redirect slice.
package superh16_pkg;

    localparam int VADDR_WIDTH  = 64;
    localparam int ROB_ENTRIES  = 64;
    localparam int ROB_IDX_BITS = $clog2(ROB_ENTRIES);

    typedef logic [VADDR_WIDTH-1:0]  vaddr_t;
    typedef logic [ROB_IDX_BITS-1:0] rob_idx_t;

    // One predictor-update record handed to the BPU.
    typedef struct packed {
        vaddr_t pc;
        vaddr_t target;
        logic   taken;
        logic   mispredicted;
    } bp_update_t;

    typedef enum logic {
        RDR_IDLE,
        RDR_FLUSH
    } redirect_state_t;

    // Distance of a ROB entry from the head; smaller is older.
    // ROB_ENTRIES is a power of two, so the modulo falls out of the width.
    function automatic rob_idx_t rob_age(input rob_idx_t idx, input rob_idx_t head);
        return idx - head;
    endfunction

endpackage

// File: rtl/superh16_bp_update_fifo.sv
// Multi-write (one slot per lane), single-read FIFO of predictor updates.
// Pushes are packed into consecutive slots in ascending lane order; lanes
// that do not fit are dropped and counted in a saturating 16-bit counter.
module superh16_bp_update_fifo
    import superh16_pkg::*;
#(
    parameter int NUM_BR = 2,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_BR-1:0]       push_i,
    input  bp_update_t [NUM_BR-1:0] push_data_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output bp_update_t              head_o,
    output logic [15:0]             drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    // One extra pointer bit separates full (MSB differs) from empty (equal).
    localparam int PW = AW + 1;

    bp_update_t        mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]     count;
    logic [PW-1:0]     free;
    logic              pop;
    logic [NUM_BR-1:0] wr_en;
    logic [AW-1:0]     wr_addr [NUM_BR];
    logic [PW-1:0]     accepted;
    logic [PW-1:0]     dropped;
    logic [16:0]       drop_sum;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign valid_o = (count != '0);
    assign pop     = valid_o & ready_i;
    // A pop in the same cycle frees its slot for this cycle's pushes.
    assign free    = PW'(DEPTH) - count + PW'(pop);

    // Assign each pushing lane the next free slot, lowest lane first.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        wr_en    = '0;
        accepted = '0;
        dropped  = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            wr_addr[i] = '0;
        end
        for (int i = 0; i < NUM_BR; i++) begin
            if (push_i[i]) begin
                if (accepted < free) begin
                    wr_en[i]   = 1'b1;
                    wr_addr[i] = AW'(wr_ptr_q + accepted);
                    accepted   = accepted + PW'(1);
                end else begin
                    dropped    = dropped + PW'(1);
                end
            end
        end
    end

    // Pointer advance and saturating drop accumulation.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + accepted;
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        drop_sum   = {1'b0, drop_cnt_q} + 17'(dropped);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Control state: pointers and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry storage, written by every accepted lane.
    // NOTE: storage is deliberately not reset; head_o is gated by valid_o so stale data never leaks.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BR; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_addr[i]] <= push_data_i[i];
            end
        end
    end

    assign head_o     = valid_o ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: rtl/superh16_branch_redirect.sv
// Branch redirect arbiter: picks the oldest mispredicting lane by ROB age,
// issues a registered redirect/flush pulse, holds a flush window, and feeds
// surviving resolved branches into the predictor-update FIFO.
module superh16_branch_redirect
    import superh16_pkg::*;
#(
    parameter int NUM_BR       = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int UPD_DEPTH    = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_BR-1:0]                      br_resolved,
    input  logic [NUM_BR-1:0]                      br_taken,
    input  logic [NUM_BR-1:0]                      br_mispredicted,
    input  logic [NUM_BR-1:0][VADDR_WIDTH-1:0]     br_target,
    input  logic [NUM_BR-1:0][VADDR_WIDTH-1:0]     br_pc,
    input  logic [NUM_BR-1:0][ROB_IDX_BITS-1:0]    br_rob_idx,
    input  logic [ROB_IDX_BITS-1:0]                rob_head_idx,
    input  logic                                   ext_flush,
    output logic                                   redirect_valid,
    output logic [VADDR_WIDTH-1:0]                 redirect_pc,
    output logic                                   flush_valid,
    output logic [ROB_IDX_BITS-1:0]                flush_rob_idx,
    output logic                                   flush_active,
    output logic                                   upd_valid,
    input  logic                                   upd_ready,
    output logic [VADDR_WIDTH-1:0]                 upd_pc,
    output logic [VADDR_WIDTH-1:0]                 upd_target,
    output logic                                   upd_taken,
    output logic                                   upd_mispredicted,
    output logic [15:0]                            upd_drop_cnt
);

    localparam int LANE_W = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;
    localparam int CNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    redirect_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rob_idx_t         cur_rob_idx_q, cur_rob_idx_d;
    logic             redirect_valid_q, redirect_valid_d;
    vaddr_t           redirect_pc_q, redirect_pc_d;
    logic             flush_valid_q, flush_valid_d;
    rob_idx_t         flush_rob_idx_q, flush_rob_idx_d;

    rob_idx_t          age [NUM_BR];
    logic              cand_found;
    logic [LANE_W-1:0] cand_lane;
    rob_idx_t          cand_age;
    rob_idx_t          cur_age;
    logic              in_flush;
    logic              take_cand;

    logic [NUM_BR-1:0]       push;
    bp_update_t [NUM_BR-1:0] push_data;
    bp_update_t              upd_head;

    assign in_flush = (state_q == RDR_FLUSH);
    assign cur_age  = rob_age(cur_rob_idx_q, rob_head_idx);

    // Oldest mispredicting lane; strict compare keeps the lower lane on a tie.
    always_comb begin
        cand_found = 1'b0;
        cand_lane  = '0;
        cand_age   = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            age[i] = rob_age(br_rob_idx[i], rob_head_idx);
            if (br_resolved[i] && br_mispredicted[i] && (!cand_found || age[i] < cand_age)) begin
                cand_found = 1'b1;
                cand_lane  = LANE_W'(i);
                cand_age   = age[i];
            end
        end
    end

    // While flushing, only a branch older than the one being flushed may redirect.
    assign take_cand = cand_found && !ext_flush && (!in_flush || cand_age < cur_age);

    // Update filter: drop lanes on the wrong path of this cycle's candidate
    // or of the branch currently being flushed.
    always_comb begin
        push = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            push[i] = br_resolved[i] && !ext_flush
                      && (!cand_found || age[i] <= cand_age)
                      && (!in_flush || age[i] <= cur_age);
            push_data[i] = '{pc:           br_pc[i],
                             target:       br_target[i],
                             taken:        br_taken[i],
                             mispredicted: br_mispredicted[i]};
        end
    end

    // Next-state and pulse generation for the redirect FSM.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        cur_rob_idx_d    = cur_rob_idx_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_valid_d    = 1'b0;
        flush_rob_idx_d  = flush_rob_idx_q;
        if (ext_flush) begin
            state_d = RDR_IDLE;
            cnt_d   = '0;
        end else if (take_cand) begin
            state_d          = RDR_FLUSH;
            cnt_d            = CNT_W'(FLUSH_CYCLES - 1);
            cur_rob_idx_d    = br_rob_idx[cand_lane];
            redirect_valid_d = 1'b1;
            redirect_pc_d    = br_target[cand_lane];
            flush_valid_d    = 1'b1;
            flush_rob_idx_d  = br_rob_idx[cand_lane];
        end else if (in_flush) begin
            if (cnt_q == '0) begin
                state_d = RDR_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // FSM state and registered redirect/flush outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RDR_IDLE;
            cnt_q            <= '0;
            cur_rob_idx_q    <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_valid_q    <= 1'b0;
            flush_rob_idx_q  <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cur_rob_idx_q    <= cur_rob_idx_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_valid_q    <= flush_valid_d;
            flush_rob_idx_q  <= flush_rob_idx_d;
        end
    end

    superh16_bp_update_fifo #(
        .NUM_BR (NUM_BR),
        .DEPTH  (UPD_DEPTH)
    ) u_upd_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .valid_o     (upd_valid),
        .ready_i     (upd_ready),
        .head_o      (upd_head),
        .drop_cnt_o  (upd_drop_cnt)
    );

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign flush_valid      = flush_valid_q;
    assign flush_rob_idx    = flush_rob_idx_q;
    assign flush_active     = in_flush;
    assign upd_pc           = upd_head.pc;
    assign upd_target       = upd_head.target;
    assign upd_taken        = upd_head.taken;
    assign upd_mispredicted = upd_head.mispredicted;

endmodule

// File: tb/tb_superh16_branch_redirect.sv
// Directed bench for superh16_branch_redirect (NUM_BR=2, FLUSH_CYCLES=2,
// UPD_DEPTH=8, ROB_ENTRIES=64). Inputs change 1ns after a rising edge and
// outputs are sampled at that same point, after the edge has settled.
module tb_superh16_branch_redirect;
    import superh16_pkg::*;

    localparam int NUM_BR = 2;

    logic                                clk;
    logic                                rst_n;
    logic [NUM_BR-1:0]                   br_resolved;
    logic [NUM_BR-1:0]                   br_taken;
    logic [NUM_BR-1:0]                   br_mispredicted;
    logic [NUM_BR-1:0][VADDR_WIDTH-1:0]  br_target;
    logic [NUM_BR-1:0][VADDR_WIDTH-1:0]  br_pc;
    logic [NUM_BR-1:0][ROB_IDX_BITS-1:0] br_rob_idx;
    logic [ROB_IDX_BITS-1:0]             rob_head_idx;
    logic                                ext_flush;
    logic                                redirect_valid;
    logic [VADDR_WIDTH-1:0]              redirect_pc;
    logic                                flush_valid;
    logic [ROB_IDX_BITS-1:0]             flush_rob_idx;
    logic                                flush_active;
    logic                                upd_valid;
    logic                                upd_ready;
    logic [VADDR_WIDTH-1:0]              upd_pc;
    logic [VADDR_WIDTH-1:0]              upd_target;
    logic                                upd_taken;
    logic                                upd_mispredicted;
    logic [15:0]                         upd_drop_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    superh16_branch_redirect #(
        .NUM_BR       (NUM_BR),
        .FLUSH_CYCLES (2),
        .UPD_DEPTH    (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .br_resolved      (br_resolved),
        .br_taken         (br_taken),
        .br_mispredicted  (br_mispredicted),
        .br_target        (br_target),
        .br_pc            (br_pc),
        .br_rob_idx       (br_rob_idx),
        .rob_head_idx     (rob_head_idx),
        .ext_flush        (ext_flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush_valid      (flush_valid),
        .flush_rob_idx    (flush_rob_idx),
        .flush_active     (flush_active),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .upd_mispredicted (upd_mispredicted),
        .upd_drop_cnt     (upd_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        br_resolved     = '0;
        br_taken        = '0;
        br_mispredicted = '0;
        br_target       = '0;
        br_pc           = '0;
        br_rob_idx      = '0;
        ext_flush       = 1'b0;
    endtask

    task automatic drive(input int lane, input logic mp, input logic [ROB_IDX_BITS-1:0] rob,
                         input logic [VADDR_WIDTH-1:0] pc, input logic [VADDR_WIDTH-1:0] tgt);
        br_resolved[lane]     = 1'b1;
        br_taken[lane]        = 1'b1;
        br_mispredicted[lane] = mp;
        br_rob_idx[lane]      = rob;
        br_pc[lane]           = pc;
        br_target[lane]       = tgt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        upd_ready = 1'b0;
        rob_head_idx = '0;
        clear_lanes();
        #12;
        vec_cnt++;
        if ({redirect_valid, flush_valid, flush_active, upd_valid} !== 4'b0) begin
            err_cnt++; $display("FAIL reset_flags: got %b required 0000", {redirect_valid, flush_valid, flush_active, upd_valid});
        end
        vec_cnt++;
        if (redirect_pc !== '0 || flush_rob_idx !== '0 || upd_drop_cnt !== 16'h0) begin
            err_cnt++; $display("FAIL reset_values: pc=%0h rob=%0d drop=%0d required all 0", redirect_pc, flush_rob_idx, upd_drop_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        rob_head_idx = 6'd5;
        drive(0, 1'b1, 6'd7, 64'h0F00, 64'h1000);
        tick();
        clear_lanes();
        vec_cnt++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h1000) begin
            err_cnt++; $display("FAIL single_redirect: valid=%b pc=%0h required 1/1000", redirect_valid, redirect_pc);
        end
        vec_cnt++;
        if (flush_valid !== 1'b1 || flush_rob_idx !== 6'd7 || flush_active !== 1'b1) begin
            err_cnt++; $display("FAIL single_flush: valid=%b rob=%0d active=%b required 1/7/1", flush_valid, flush_rob_idx, flush_active);
        end
        vec_cnt++;
        if (upd_valid !== 1'b1 || upd_pc !== 64'h0F00 || upd_target !== 64'h1000 || upd_mispredicted !== 1'b1) begin
            err_cnt++; $display("FAIL single_upd: valid=%b pc=%0h tgt=%0h mp=%b required 1/f00/1000/1", upd_valid, upd_pc, upd_target, upd_mispredicted);
        end
        tick();
        vec_cnt++;
        if (redirect_valid !== 1'b0 || flush_valid !== 1'b0 || flush_active !== 1'b1) begin
            err_cnt++; $display("FAIL single_second: rv=%b fv=%b active=%b required 0/0/1", redirect_valid, flush_valid, flush_active);
        end
        tick();
        vec_cnt++;
        if (flush_active !== 1'b0) begin
            err_cnt++; $display("FAIL single_window_end: active=%b required 0", flush_active);
        end
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        vec_cnt++;
        if (upd_valid !== 1'b0) begin
            err_cnt++; $display("FAIL single_one_entry: upd_valid=%b required 0", upd_valid);
        end
    endtask

    // Lane1 (rob 62, age 2) is older than lane0 (rob 2, age 6). Lane0 sits on
    // lane1's wrong path, so only lane1 reaches the update FIFO.
    task automatic test_dual_wrap();
        rob_head_idx = 6'd60;
        drive(0, 1'b1, 6'd2,  64'h1F00, 64'h2000);
        drive(1, 1'b1, 6'd62, 64'h2F00, 64'h3000);
        tick();
        clear_lanes();
        vec_cnt++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h3000 || flush_rob_idx !== 6'd62) begin
            err_cnt++; $display("FAIL dual_redirect: rv=%b pc=%0h rob=%0d required 1/3000/62", redirect_valid, redirect_pc, flush_rob_idx);
        end
        vec_cnt++;
        if (upd_valid !== 1'b1 || upd_pc !== 64'h2F00) begin
            err_cnt++; $display("FAIL dual_upd_head: valid=%b pc=%0h required 1/2f00", upd_valid, upd_pc);
        end
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        vec_cnt++;
        if (upd_valid !== 1'b0) begin
            err_cnt++; $display("FAIL dual_filtered: upd_valid=%b required 0", upd_valid);
        end
        tick();
        vec_cnt++;
        if (flush_active !== 1'b0) begin
            err_cnt++; $display("FAIL dual_window_end: active=%b required 0", flush_active);
        end
    endtask

    task automatic test_re_redirect();
        logic [VADDR_WIDTH-1:0] exp_pc [2];
        exp_pc[0] = 64'h3F00;
        exp_pc[1] = 64'h4F00;
        rob_head_idx = 6'd10;
        drive(0, 1'b1, 6'd20, 64'h3F00, 64'h4000);
        tick();
        clear_lanes();
        vec_cnt++;
        if (redirect_valid !== 1'b1 || flush_rob_idx !== 6'd20) begin
            err_cnt++; $display("FAIL rr_first: rv=%b rob=%0d required 1/20", redirect_valid, flush_rob_idx);
        end
        drive(1, 1'b1, 6'd15, 64'h4F00, 64'h5000);
        tick();
        clear_lanes();
        vec_cnt++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'h5000 || flush_rob_idx !== 6'd15 || flush_active !== 1'b1) begin
            err_cnt++; $display("FAIL rr_second: rv=%b pc=%0h rob=%0d active=%b required 1/5000/15/1", redirect_valid, redirect_pc, flush_rob_idx, flush_active);
        end
        drive(0, 1'b1, 6'd25, 64'h5F00, 64'h6000);
        tick();
        clear_lanes();
        vec_cnt++;
        if (redirect_valid !== 1'b0 || flush_rob_idx !== 6'd15 || flush_active !== 1'b1) begin
            err_cnt++; $display("FAIL rr_younger_ignored: rv=%b rob=%0d active=%b required 0/15/1", redirect_valid, flush_rob_idx, flush_active);
        end
        tick();
        vec_cnt++;
        if (flush_active !== 1'b0) begin
            err_cnt++; $display("FAIL rr_window_end: active=%b required 0", flush_active);
        end
        upd_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            vec_cnt++;
            if (upd_valid !== 1'b1 || upd_pc !== exp_pc[k]) begin
                err_cnt++; $display("FAIL rr_upd_%0d: valid=%b pc=%0h required 1/%0h", k, upd_valid, upd_pc, exp_pc[k]);
            end
            tick();
        end
        upd_ready = 1'b0;
        vec_cnt++;
        if (upd_valid !== 1'b0) begin
            err_cnt++; $display("FAIL rr_no_younger_push: upd_valid=%b required 0", upd_valid);
        end
    endtask

    task automatic test_ext_flush();
        rob_head_idx = 6'd0;
        drive(0, 1'b0, 6'd3, 64'h7000, 64'h7004);
        tick();
        clear_lanes();
        drive(0, 1'b1, 6'd4, 64'h7100, 64'h8000);
        ext_flush = 1'b1;
        tick();
        clear_lanes();
        vec_cnt++;
        if (redirect_valid !== 1'b0 || flush_valid !== 1'b0 || flush_active !== 1'b0) begin
            err_cnt++; $display("FAIL ext_no_pulse: rv=%b fv=%b active=%b required 0/0/0", redirect_valid, flush_valid, flush_active);
        end
        vec_cnt++;
        if (upd_valid !== 1'b1 || upd_pc !== 64'h7000) begin
            err_cnt++; $display("FAIL ext_fifo_kept: valid=%b pc=%0h required 1/7000", upd_valid, upd_pc);
        end
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        vec_cnt++;
        if (upd_valid !== 1'b0) begin
            err_cnt++; $display("FAIL ext_no_push: upd_valid=%b required 0", upd_valid);
        end
        // ext_flush while flushing: window ends at once, older mispredict discarded.
        drive(0, 1'b1, 6'd4, 64'h7100, 64'h8000);
        tick();
        clear_lanes();
        drive(1, 1'b1, 6'd2, 64'h7200, 64'h9000);
        ext_flush = 1'b1;
        tick();
        clear_lanes();
        vec_cnt++;
        if (flush_active !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 64'h8000) begin
            err_cnt++; $display("FAIL ext_in_flush: active=%b rv=%b pc=%0h required 0/0/8000", flush_active, redirect_valid, redirect_pc);
        end
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        vec_cnt++;
        if (upd_valid !== 1'b0) begin
            err_cnt++; $display("FAIL ext_in_flush_fifo: upd_valid=%b required 0", upd_valid);
        end
    endtask

    task automatic test_fifo_full();
        logic [VADDR_WIDTH-1:0] exp_pc [8];
        for (int k = 0; k < 6; k++) exp_pc[k] = 64'(k + 2) << 8;
        exp_pc[6] = 64'hA00;
        exp_pc[7] = 64'hC00;
        rob_head_idx = 6'd0;
        upd_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(0, 1'b0, 6'(2 * c),     64'(2 * c + 1) << 8, 64'h0);
            drive(1, 1'b0, 6'(2 * c + 1), 64'(2 * c + 2) << 8, 64'h0);
            tick();
        end
        clear_lanes();
        drive(0, 1'b0, 6'd6, 64'h700, 64'h0);
        tick();
        clear_lanes();
        // Seven entries held: lane0 fits, lane1 is dropped.
        drive(0, 1'b0, 6'd7, 64'hA00, 64'h0);
        drive(1, 1'b0, 6'd8, 64'hB00, 64'h0);
        tick();
        clear_lanes();
        vec_cnt++;
        if (upd_drop_cnt !== 16'd1 || upd_valid !== 1'b1) begin
            err_cnt++; $display("FAIL full_drop: drop=%0d valid=%b required 1/1", upd_drop_cnt, upd_valid);
        end
        // Full with a pop: exactly one push is accepted.
        upd_ready = 1'b1;
        drive(0, 1'b0, 6'd9,  64'hC00, 64'h0);
        drive(1, 1'b0, 6'd10, 64'hD00, 64'h0);
        tick();
        clear_lanes();
        vec_cnt++;
        if (upd_drop_cnt !== 16'd2) begin
            err_cnt++; $display("FAIL full_pop_push: drop=%0d required 2", upd_drop_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            vec_cnt++;
            if (upd_valid !== 1'b1 || upd_pc !== exp_pc[k]) begin
                err_cnt++; $display("FAIL full_order_%0d: valid=%b pc=%0h required 1/%0h", k, upd_valid, upd_pc, exp_pc[k]);
            end
            tick();
        end
        upd_ready = 1'b0;
        vec_cnt++;
        if (upd_valid !== 1'b0) begin
            err_cnt++; $display("FAIL full_drained: upd_valid=%b required 0", upd_valid);
        end
    endtask

    task automatic test_reset_mid_flush();
        rob_head_idx = 6'd5;
        drive(0, 1'b1, 6'd7, 64'h0F00, 64'h1000);
        tick();
        clear_lanes();
        vec_cnt++;
        if (flush_active !== 1'b1 || upd_valid !== 1'b1) begin
            err_cnt++; $display("FAIL rst_pre: active=%b upd_valid=%b required 1/1", flush_active, upd_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({redirect_valid, flush_valid, flush_active, upd_valid} !== 4'b0) begin
            err_cnt++; $display("FAIL rst_async_flags: got %b required 0000", {redirect_valid, flush_valid, flush_active, upd_valid});
        end
        vec_cnt++;
        if (redirect_pc !== '0 || flush_rob_idx !== '0 || upd_drop_cnt !== 16'h0 || upd_pc !== '0) begin
            err_cnt++; $display("FAIL rst_async_values: pc=%0h rob=%0d drop=%0d upd_pc=%0h required all 0", redirect_pc, flush_rob_idx, upd_drop_cnt, upd_pc);
        end
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vec_cnt++;
            if ({redirect_valid, flush_valid, flush_active, upd_valid} !== 4'b0) begin
                err_cnt++; $display("FAIL rst_quiet_%0d: got %b required 0000", k, {redirect_valid, flush_valid, flush_active, upd_valid});
            end
        end
        drive(1, 1'b1, 6'd9, 64'hE00, 64'hE40);
        tick();
        clear_lanes();
        vec_cnt++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 64'hE40 || flush_rob_idx !== 6'd9) begin
            err_cnt++; $display("FAIL rst_new_redirect: rv=%b pc=%0h rob=%0d required 1/e40/9", redirect_valid, redirect_pc, flush_rob_idx);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_wrap();
        test_re_redirect();
        test_ext_flush();
        test_fifo_full();
        test_reset_mid_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
